vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator that produces horizontal/vertical sync, active-video flag, pixel coordinates and line/frame start strobes for any display mode. It sits at the head of the video pipeline and drives the character/pixel rendering path. A pixel-clock enable lets it run from a faster system clock. A configurable output delay aligns sync with downstream pipelined pixel data such as the character ROM fetch.

---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_sync_delay.sv | 56 +++++
 rtl/vga_timing_gen.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and defaults.
// Default timing constants are 640x480@60.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   localparam int PIX_W    = 16;
   localparam int PIPE_MAX = 7;

   typedef struct packed {
      logic             hsync;
      logic             vsync;
      logic             video_active;
      logic [PIX_W-1:0] pixel_x;
      logic [PIX_W-1:0] pixel_y;
      logic             line_start;
      logic             frame_start;
   } vga_sig_t;

   function automatic vga_sig_t vga_idle(
      input bit h_pol,
      input bit v_pol
   );
      vga_sig_t s;
      s       = '0;
      s.hsync = ~h_pol;
      s.vsync = ~v_pol;
      return s;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated delay line for the VGA signal bundle.
// Stages reset to the idle bundle so no strobe leaks during fill.
module vga_sync_delay
   import vga_timing_pkg::*;
#(
   parameter int       DEPTH = 0,
   parameter vga_sig_t IDLE  = '0
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     en_i,
   input  vga_sig_t d_i,
   output vga_sig_t q_o,
   output vga_sig_t pre_o
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = clk ^ reset ^ en_i;
      assign q_o   = d_i;
      assign pre_o = d_i;
   end else begin : g_pipe
      vga_sig_t stg_q [DEPTH];
      vga_sig_t stg_d [DEPTH];

      always_comb begin
         stg_d = stg_q;
         if (en_i) begin
            stg_d[0] = d_i;
            for (int i = 1; i < DEPTH; i++) begin
               stg_d[i] = stg_q[i-1];
            end
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
               stg_q[i] <= IDLE;
            end
         end else begin
            stg_q <= stg_d;
         end
      end

      assign q_o = stg_q[DEPTH-1];

      // pre_o is what the final stage loads on the next enabled edge
      if (DEPTH == 1) begin : g_pre_in
         assign pre_o = d_i;
      end else begin : g_pre_stg
         assign pre_o = stg_q[DEPTH-2];
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel enable and output delay.
// Define VGA_TIMING_FRAME_CNT_EN to add the frame_count output.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit H_POL    = SYNC_ACTIVE_LOW,
   parameter bit V_POL    = SYNC_ACTIVE_LOW,
   parameter int CW       = 12,
   parameter int PIPE     = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          video_active,
   output logic [CW-1:0] pixel_x,
   output logic [CW-1:0] pixel_y,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]   frame_count
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

   localparam vga_sig_t IDLE = vga_idle(H_POL, V_POL);

   if (CW < 1 || CW > PIX_W) begin : g_bad_cw
      $error("vga_timing_gen: CW out of range");
   end
   if (longint'(H_TOTAL) > (longint'(1) << CW) ||
       longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_bad_total
      $error("vga_timing_gen: total exceeds counter range");
   end
   if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
      $error("vga_timing_gen: porch and sync widths must be nonzero");
   end
   if (PIPE < 0 || PIPE > PIPE_MAX) begin : g_bad_pipe
      $error("vga_timing_gen: PIPE out of range");
   end

   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;
   vga_sig_t      cur;
   vga_sig_t      st_q, st_d;
   vga_sig_t      out;
   vga_sig_t      pre;

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pix_en) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
               v_d = '0;
            end else begin
               v_d = v_q + 1'b1;
            end
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_comb begin
      cur              = IDLE;
      cur.video_active = (h_q < H_ACT) && (v_q < V_ACT);
      cur.hsync        = (h_q >= HS_BEG && h_q < HS_END) ? H_POL : ~H_POL;
      cur.vsync        = (v_q >= VS_BEG && v_q < VS_END) ? V_POL : ~V_POL;
      if (cur.video_active) begin
         cur.pixel_x = PIX_W'(h_q);
         cur.pixel_y = PIX_W'(v_q);
      end
      cur.line_start  = (h_q == '0);
      cur.frame_start = (h_q == '0) && (v_q == '0);
   end

   always_comb begin
      st_d = st_q;
      if (pix_en) begin
         st_d = cur;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q  <= '0;
         v_q  <= '0;
         st_q <= IDLE;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         st_q <= st_d;
      end
   end

   vga_sync_delay #(
      .DEPTH (PIPE),
      .IDLE  (IDLE)
   ) u_dly (
      .clk   (clk),
      .reset (reset),
      .en_i  (pix_en),
      .d_i   (st_q),
      .q_o   (out),
      .pre_o (pre)
   );

   assign hsync        = out.hsync;
   assign vsync        = out.vsync;
   assign video_active = out.video_active;
   assign pixel_x      = out.pixel_x[CW-1:0];
   assign pixel_y      = out.pixel_y[CW-1:0];
   assign line_start   = out.line_start;
   assign frame_start  = out.frame_start;

   logic unused_pix;
   assign unused_pix = ^{out.pixel_x, out.pixel_y};

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] fc_q, fc_d;
   logic        fs_load;

   // Count on the edge that loads frame_start into the last output stage
   assign fs_load = (PIPE == 0) ? cur.frame_start : pre.frame_start;

   always_comb begin
      fc_d = fc_q;
      if (pix_en && fs_load) begin
         fc_d = fc_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fc_q <= '0;
      end else begin
         fc_q <= fc_d;
      end
   end

   assign frame_count = fc_q;
`else
   logic unused_pre;
   assign unused_pre = ^pre;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus 7x5 tiny-mode instances
// (PIPE=0, PIPE=3, inverted polarity) sharing clock, reset and pix_en.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic pix_en = 1'b1;

   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;

   // tiny mode: h 0..3 active, 4 fp, 5 sync, 6 bp; v 0..1 active, 2 fp, 3 sync, 4 bp
   logic [6:0] hs_tab  = 7'b0100000;
   logic [6:0] hac_tab = 7'b0001111;
   logic [4:0] vs_tab  = 5'b01000;
   logic [4:0] vac_tab = 5'b00011;

   logic a_hs, a_vs, a_act, a_ls, a_fs;
   logic [11:0] a_px, a_py;
   logic b_hs, b_vs, b_act, b_ls, b_fs;
   logic [3:0] b_px, b_py;
   logic c_hs, c_vs, c_act, c_ls, c_fs;
   logic [3:0] c_px, c_py;
   logic d_hs, d_vs, d_act, d_ls, d_fs;
   logic [3:0] d_px, d_py;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] a_fc, b_fc, c_fc, d_fc;
`endif

   vga_timing_gen u_a (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .hsync(a_hs), .vsync(a_vs), .video_active(a_act),
      .pixel_x(a_px), .pixel_y(a_py),
      .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_count(a_fc)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(4)
   ) u_b (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .hsync(b_hs), .vsync(b_vs), .video_active(b_act),
      .pixel_x(b_px), .pixel_y(b_py),
      .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_count(b_fc)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(4),
      .PIPE(3)
   ) u_c (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .hsync(c_hs), .vsync(c_vs), .video_active(c_act),
      .pixel_x(c_px), .pixel_y(c_py),
      .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_count(c_fc)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(4),
      .H_POL(1), .V_POL(1)
   ) u_d (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .hsync(d_hs), .vsync(d_vs), .video_active(d_act),
      .pixel_x(d_px), .pixel_y(d_py),
      .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_count(d_fc)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // idx = raster position index presented at the output (<0: pipeline idle)
   task automatic chk_tiny(input string tag, input int idx, input bit pol,
                           input logic hs, input logic vs, input logic act,
                           input logic ls, input logic fs,
                           input logic [3:0] px, input logic [3:0] py);
      int h, v;
      logic ehs, evs, eact, els, efs;
      logic [3:0] epx, epy;
      if (idx < 0) begin
         ehs = !pol; evs = !pol;
         eact = 0; els = 0; efs = 0;
         epx = 0; epy = 0;
      end else begin
         h = idx % 7;
         v = (idx / 7) % 5;
         eact = hac_tab[h] && vac_tab[v];
         ehs = hs_tab[h] ? pol : !pol;
         evs = vs_tab[v] ? pol : !pol;
         els = (h == 0);
         efs = (h == 0) && (v == 0);
         epx = eact ? 4'(h) : 4'd0;
         epy = eact ? 4'(v) : 4'd0;
      end
      chk({tag, ".sync"}, {hs, vs}, {ehs, evs});
      chk({tag, ".flags"}, {act, ls, fs}, {eact, els, efs});
      chk({tag, ".pix"}, {px, py}, {epx, epy});
   endtask

   int hs_first, hs_last, hs_lows, vs_lows;
   int ls_cnt, ls_second, ls_hi;
   int fs_r1, fs_r2;
   logic ls_prev, fs_prev;
   bit found;

   initial begin
      // reset state
      reset = 1'b1;
      pix_en = 1'b1;
      step();
      step();
      chk("rst.a.sync", {a_hs, a_vs}, 2'b11);
      chk("rst.a.flags", {a_act, a_ls, a_fs}, 3'b000);
      chk("rst.a.pix", {a_px, a_py}, 24'h0);
      chk("rst.d.sync", {d_hs, d_vs}, 2'b00);
      chk_tiny("rst.b", -1, 1'b0, b_hs, b_vs, b_act, b_ls, b_fs, b_px, b_py);
      chk_tiny("rst.c", -1, 1'b0, c_hs, c_vs, c_act, c_ls, c_fs, c_px, c_py);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("rst.fc", b_fc, 16'd0);
`endif

      // free-running raster
      reset = 1'b0;
      hs_first = 0; hs_last = 0; hs_lows = 0; vs_lows = 0;
      ls_cnt = 0; ls_second = 0; ls_prev = 1'b0;
      for (int n = 1; n <= 1601; n++) begin
         step();
         if (n <= 40) begin
            chk_tiny("b", n - 1, 1'b0,
                     b_hs, b_vs, b_act, b_ls, b_fs, b_px, b_py);
            chk_tiny("c", n - 4, 1'b0,
                     c_hs, c_vs, c_act, c_ls, c_fs, c_px, c_py);
            chk_tiny("d", n - 1, 1'b1,
                     d_hs, d_vs, d_act, d_ls, d_fs, d_px, d_py);
         end
         if (n == 1) begin
            chk("a.first.flags", {a_act, a_ls, a_fs}, 3'b111);
            chk("a.first.pix", {a_px, a_py}, 24'h0);
            chk("a.first.sync", {a_hs, a_vs}, 2'b11);
         end
         if (n == 801) begin
            chk("a.line1.flags", {a_act, a_ls, a_fs}, 3'b110);
            chk("a.line1.pix", {a_px, a_py}, {12'd0, 12'd1});
         end
`ifdef VGA_TIMING_FRAME_CNT_EN
         if (n == 1) chk("fc.b.1", b_fc, 16'd1);
         if (n == 3) chk("fc.c.3", c_fc, 16'd0);
         if (n == 4) chk("fc.c.4", c_fc, 16'd1);
         if (n == 36) chk("fc.b.36", b_fc, 16'd2);
`endif
         if (n <= 800 && a_hs === 1'b0) begin
            hs_lows++;
            if (hs_first == 0) hs_first = n;
            hs_last = n;
         end
         if (a_vs !== 1'b1) vs_lows++;
         if (a_ls && !ls_prev) begin
            ls_cnt++;
            if (ls_cnt == 2) ls_second = n;
         end
         ls_prev = a_ls;
      end
      chk("a.hs.first", hs_first, 657);
      chk("a.hs.last", hs_last, 752);
      chk("a.hs.width", hs_lows, 96);
      chk("a.vs.idle", vs_lows, 0);
      chk("a.ls.count", ls_cnt, 3);
      chk("a.ls.period", ls_second, 801);

`ifdef VGA_TIMING_FRAME_CNT_EN
      // frame counter wrap
      force u_b.fc_q = 16'hFFFF;
      #1;
      release u_b.fc_q;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         step();
         if (b_fs === 1'b1) found = 1'b1;
      end
      chk("fc.wrap.seen", found, 1'b1);
      chk("fc.wrap", b_fc, 16'd0);
`endif

      // pix_en toggling every clock
      reset = 1'b1;
      step();
      reset = 1'b0;
      ls_cnt = 0; ls_second = 0; ls_hi = 0; ls_prev = 1'b0;
      fs_r1 = 0; fs_r2 = 0; fs_prev = 1'b0;
      for (int k = 1; k <= 1700; k++) begin
         pix_en = (k % 2 == 1);
         step();
         if (k == 2) chk("en.b.fs.hold", b_fs, 1'b1);
         if (k == 3) chk("en.b.fs.drop", b_fs, 1'b0);
         if (k == 3) chk("en.b.px", b_px, 4'd1);
         if (a_ls) ls_hi++;
         if (a_ls && !ls_prev) begin
            ls_cnt++;
            if (ls_cnt == 2) ls_second = k;
         end
         ls_prev = a_ls;
         if (b_fs && !fs_prev) begin
            if (fs_r1 == 0) fs_r1 = k;
            else if (fs_r2 == 0) fs_r2 = k;
         end
         fs_prev = b_fs;
      end
      pix_en = 1'b1;
      chk("en.a.ls.hi", ls_hi, 4);
      chk("en.a.ls.period", ls_second, 1601);
      chk("en.b.fs.first", fs_r1, 1);
      chk("en.b.fs.period", fs_r2, 71);

      // reset mid-frame
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (10) step();
      chk("mid.b.pix", {b_px, b_py}, {4'd2, 4'd1});
      chk("mid.b.act", b_act, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk_tiny("mid.rst.b", -1, 1'b0,
               b_hs, b_vs, b_act, b_ls, b_fs, b_px, b_py);
      chk("mid.rst.a", {a_act, a_ls, a_fs, a_hs, a_vs}, 5'b00011);
      chk("mid.rst.d", {d_hs, d_vs}, 2'b00);
      step();
      reset = 1'b0;
      step();
      chk_tiny("mid.rel.b", 0, 1'b0,
               b_hs, b_vs, b_act, b_ls, b_fs, b_px, b_py);
      chk("mid.rel.a", {a_act, a_ls, a_fs}, 3'b111);
      chk("mid.rel.c", {c_act, c_ls, c_fs}, 3'b000);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("mid.rel.fc", b_fc, 16'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
